// File: rtl/onehot_rot_pkg.sv
// Shared encodings and the pos-to-one-hot decode for onehot_rotator and related scan blocks.
package onehot_rot_pkg;

  localparam logic DIR_LEFT    = 1'b0;
  localparam logic DIR_RIGHT   = 1'b1;
  localparam logic MODE_WRAP   = 1'b0;
  localparam logic MODE_BOUNCE = 1'b1;

  // Widest one-hot vector the decode can produce; callers size-cast the result down.
  localparam int MAX_WIDTH = 64;

  function automatic logic [MAX_WIDTH-1:0] pos_to_onehot(input logic [31:0] p);
    return {{(MAX_WIDTH-1){1'b0}}, 1'b1} << p;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Step-strobe generator: tick_o is high (combinationally) in every DIV-th enabled cycle.
// Count freezes while en is low; clr zeroes the count and suppresses a coincident tick.
module tick_prescaler #(
  parameter int DIV = 25000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick_o
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick_o = en & ~clr & (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/onehot_rotator.sv
// Parametrised one-hot position generator (wrap/bounce, left/right, load, step tick); q/pos/tick registered.
// Optional self-check adding a sticky err output is compiled in with ONEHOT_ROT_CHECK_EN.
module onehot_rotator
  import onehot_rot_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int DIV      = 25000,
  parameter int INIT_POS = 3,
  localparam int POS_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             dir,
  input  logic             mode,
  input  logic             load,
  input  logic [POS_W-1:0] load_pos,
  output logic [WIDTH-1:0] q,
  output logic [POS_W-1:0] pos,
  output logic             tick
`ifdef ONEHOT_ROT_CHECK_EN
  ,
  output logic             err
`endif
);

  localparam logic [POS_W-1:0] LAST   = POS_W'(WIDTH - 1);
  localparam logic [POS_W-1:0] INIT   = POS_W'(INIT_POS);
  localparam logic [WIDTH-1:0] INIT_Q = WIDTH'(pos_to_onehot(INIT_POS));

  logic             step;
  logic             clr;
  logic             fault;
  logic             bdir;
  logic             bdir_next;
  logic             mv_dir;
  logic [POS_W-1:0] pos_next;
  logic [POS_W-1:0] load_cl;
  logic [WIDTH-1:0] q_next;

  assign clr = load | fault;

  tick_prescaler #(
    .DIV(DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .clr   (clr),
    .tick_o(step)
  );

`ifdef ONEHOT_ROT_CHECK_EN
  logic [WIDTH-1:0] q_of_pos;

  assign q_of_pos = WIDTH'(pos_to_onehot(32'(pos)));
  assign fault    = (q == '0) || ((q & (q - WIDTH'(1))) != '0) || (q != q_of_pos);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (fault) begin
      err <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n && fault) begin
      $error("onehot_rotator: q=%b inconsistent with pos=%0d", q, pos);
    end
  end
`endif
`else
  assign fault = 1'b0;
`endif

  // In wrap mode bdir shadows dir so a switch to bounce continues in the last direction.
  always_comb begin
    mv_dir    = (mode == MODE_BOUNCE) ? bdir : dir;
    bdir_next = (mode == MODE_WRAP) ? dir : bdir;
    load_cl   = (load_pos > LAST) ? LAST : load_pos;
    pos_next  = pos;
    if (fault) begin
      pos_next = INIT;
    end else if (load) begin
      pos_next = load_cl;
    end else if (step && (WIDTH > 1)) begin
      if ((mode == MODE_BOUNCE) && (bdir == DIR_LEFT) && (pos == LAST)) begin
        bdir_next = DIR_RIGHT;
        pos_next  = LAST - POS_W'(1);
      end else if ((mode == MODE_BOUNCE) && (bdir == DIR_RIGHT) && (pos == '0)) begin
        bdir_next = DIR_LEFT;
        pos_next  = POS_W'(1);
      end else if (mv_dir == DIR_LEFT) begin
        pos_next = (pos == LAST) ? '0 : pos + POS_W'(1);
      end else begin
        pos_next = (pos == '0) ? LAST : pos - POS_W'(1);
      end
    end
    q_next = WIDTH'(pos_to_onehot(32'(pos_next)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos  <= INIT;
      q    <= INIT_Q;
      tick <= 1'b0;
      bdir <= DIR_LEFT;
    end else begin
      pos  <= pos_next;
      q    <= q_next;
      tick <= step;
      bdir <= bdir_next;
    end
  end

endmodule

// File: tb/tb_onehot_rotator.sv
// Directed bench for onehot_rotator: three instances cover wrap-left, wrap-right/pause/clamp, and bounce.
module tb_onehot_rotator;

  logic clk = 1'b0;
  logic rst_n;

  logic       en_a, dir_a, mode_a, load_a, tick_a;
  logic [1:0] load_pos_a, pos_a;
  logic [3:0] q_a;

  logic       en_b, dir_b, mode_b, load_b, tick_b;
  logic [2:0] load_pos_b, pos_b;
  logic [4:0] q_b;

  logic       en_c, dir_c, mode_c, load_c, tick_c;
  logic [1:0] load_pos_c, pos_c;
  logic [3:0] q_c;

`ifdef ONEHOT_ROT_CHECK_EN
  logic err_a, err_b, err_c;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  onehot_rotator #(.WIDTH(4), .DIV(4), .INIT_POS(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .dir(dir_a), .mode(mode_a), .load(load_a),
    .load_pos(load_pos_a), .q(q_a), .pos(pos_a), .tick(tick_a)
`ifdef ONEHOT_ROT_CHECK_EN
    , .err(err_a)
`endif
  );

  onehot_rotator #(.WIDTH(5), .DIV(3), .INIT_POS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .dir(dir_b), .mode(mode_b), .load(load_b),
    .load_pos(load_pos_b), .q(q_b), .pos(pos_b), .tick(tick_b)
`ifdef ONEHOT_ROT_CHECK_EN
    , .err(err_b)
`endif
  );

  onehot_rotator #(.WIDTH(4), .DIV(1), .INIT_POS(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .en(en_c), .dir(dir_c), .mode(mode_c), .load(load_c),
    .load_pos(load_pos_c), .q(q_c), .pos(pos_c), .tick(tick_c)
`ifdef ONEHOT_ROT_CHECK_EN
    , .err(err_c)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    logic [3:0] exp_q;
    int         seq_b [6] = '{4, 3, 2, 1, 0, 4};
    int         seq_c [7] = '{1, 2, 3, 2, 1, 0, 1};

    rst_n = 1'b0;
    en_a = 1'b1; dir_a = 1'b0; mode_a = 1'b0; load_a = 1'b0; load_pos_a = 2'd0;
    en_b = 1'b0; dir_b = 1'b0; mode_b = 1'b0; load_b = 1'b0; load_pos_b = 3'd0;
    en_c = 1'b0; dir_c = 1'b0; mode_c = 1'b1; load_c = 1'b0; load_pos_c = 2'd0;

    @(negedge clk);
    chk("rst_q_a", 32'(q_a), 32'h8);
    chk("rst_pos_a", 32'(pos_a), 3);
    chk("rst_tick_a", 32'(tick_a), 0);
    chk("rst_q_b", 32'(q_b), 32'h1);
    chk("rst_q_c", 32'(q_c), 32'h1);
    rst_n = 1'b1;

    // A: wrap left, one step per 4 enabled cycles: 1000 -> 0001 -> 0010 -> 0100 -> 1000
    exp_q = 4'b1000;
    for (int k = 0; k < 4; k++) begin
      cyc(3);
      chk("a_hold_tick", 32'(tick_a), 0);
      chk("a_hold_q", 32'(q_a), 32'(exp_q));
      exp_q = {exp_q[2:0], exp_q[3]};
      cyc(1);
      chk("a_step_q", 32'(q_a), 32'(exp_q));
      chk("a_step_tick", 32'(tick_a), 1);
    end

    // A: load coincident with a due step wins and suppresses the tick
    cyc(3);
    load_a = 1'b1; load_pos_a = 2'd2;
    cyc(1);
    load_a = 1'b0;
    chk("a_load_pos", 32'(pos_a), 2);
    chk("a_load_q", 32'(q_a), 32'h4);
    chk("a_load_tick", 32'(tick_a), 0);
    cyc(3);
    chk("a_after_load_hold", 32'(pos_a), 2);
    cyc(1);
    chk("a_after_load_pos", 32'(pos_a), 3);
    chk("a_after_load_tick", 32'(tick_a), 1);

    // B: wrap right from pos 0 with DIV=3
    en_b = 1'b1; dir_b = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cyc(2);
      chk("b_hold_tick", 32'(tick_b), 0);
      cyc(1);
      chk("b_step_pos", 32'(pos_b), 32'(seq_b[k]));
      chk("b_step_q", 32'(q_b), 32'(1) << seq_b[k]);
      chk("b_step_tick", 32'(tick_b), 1);
    end

    // B: en low for 3 cycles mid-period pushes the next step out by 3 cycles
    cyc(1);
    en_b = 1'b0;
    cyc(3);
    chk("b_pause_pos", 32'(pos_b), 4);
    chk("b_pause_tick", 32'(tick_b), 0);
    en_b = 1'b1;
    cyc(1);
    chk("b_resume_hold", 32'(tick_b), 0);
    cyc(1);
    chk("b_resume_pos", 32'(pos_b), 3);
    chk("b_resume_tick", 32'(tick_b), 1);

    // B: load with en low; out-of-range load_pos clamps to WIDTH-1
    en_b = 1'b0; load_b = 1'b1; load_pos_b = 3'd7;
    cyc(1);
    chk("b_clamp_pos", 32'(pos_b), 4);
    chk("b_clamp_q", 32'(q_b), 32'h10);
    chk("b_clamp_tick", 32'(tick_b), 0);
    load_pos_b = 3'd2;
    cyc(1);
    load_b = 1'b0;
    chk("b_load_dis_pos", 32'(pos_b), 2);

    // C: bounce with DIV=1, dir toggled every cycle and ignored
    en_c = 1'b1;
    for (int k = 0; k < 7; k++) begin
      dir_c = ~dir_c;
      cyc(1);
      chk("c_bounce_pos", 32'(pos_c), 32'(seq_c[k]));
      chk("c_bounce_q", 32'(q_c), 32'(1) << seq_c[k]);
      chk("c_bounce_tick", 32'(tick_c), 1);
    end
    en_c = 1'b0;

    // A: asynchronous reset between edges, mid-period
    load_a = 1'b1; load_pos_a = 2'd1;
    cyc(1);
    load_a = 1'b0;
    cyc(2);
    chk("a_pre_rst_pos", 32'(pos_a), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("a_async_rst_q", 32'(q_a), 32'h8);
    chk("a_async_rst_pos", 32'(pos_a), 3);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(3);
    chk("a_post_rst_hold_q", 32'(q_a), 32'h8);
    chk("a_post_rst_hold_tick", 32'(tick_a), 0);
    cyc(1);
    chk("a_post_rst_step_q", 32'(q_a), 32'h1);
    chk("a_post_rst_step_tick", 32'(tick_a), 1);

`ifdef ONEHOT_ROT_CHECK_EN
    chk("a_err_clear", 32'(err_a), 0);
    force dut_a.q = 4'b0110;
    #1;
    release dut_a.q;
    cyc(1);
    chk("a_err_set", 32'(err_a), 1);
    chk("a_err_q_recover", 32'(q_a), 32'h8);
    chk("a_err_pos_recover", 32'(pos_a), 3);
    cyc(1);
    chk("a_err_sticky", 32'(err_a), 1);
    chk("b_err_clear", 32'(err_b), 0);
    chk("c_err_clear", 32'(err_c), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
